// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: sequencer state encoding, the halt opcode
// default and the control-flow opcodes also decoded by Control_Unit.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'h3F;
    localparam logic [5:0] OP_BEQ          = 6'h04;
    localparam logic [5:0] OP_J            = 6'h02;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC for one committing instruction: jump beats taken
// branch beats sequential; all arithmetic wraps at PC_W bits.
module pc_next_logic #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [31:0]     instruction,
    input  logic            branch,
    input  logic            jump,
    input  logic            zero,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] imm_pc;
    logic            unused_bits;

    assign pc_inc      = pc + PC_W'(1);
    // Size cast of a signed value sign-extends or truncates to PC_W.
    assign imm_pc      = PC_W'($signed(instruction[15:0]));
    assign unused_bits = ^instruction;

    always_comb begin
        next_pc = pc_inc;
        if (jump)
            next_pc = instruction[PC_W-1:0];
        else if (branch && zero)
            next_pc = pc_inc + imm_pc;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and IDLE/RUN/HALT run controller for the single-cycle core.
// Define PC_RETIRE_CNT_EN to add the saturating retire_count output.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int              PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [5:0]      HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stall,
    input  logic [31:0]     instruction,
    input  logic            branch,
    input  logic            jump,
    input  logic            zero,
    output logic [PC_W-1:0] program_counter,
    output logic            pc_valid,
    output logic            halted,
`ifdef PC_RETIRE_CNT_EN
    output logic [31:0]     retire_count,
`endif
    output logic [1:0]      seq_state
);

    seq_state_t      state, state_nxt;
    logic [PC_W-1:0] pc_seq, pc_d;
    logic            is_halt;
    logic            start_acc;

    assign is_halt   = (instruction[31:26] == HALT_OPCODE);
    assign pc_valid  = (state == RUN) && !stall && !is_halt;
    assign seq_state = state;

    pc_next_logic #(.PC_W(PC_W)) u_next (
        .pc          (program_counter),
        .instruction (instruction),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
        .next_pc     (pc_seq)
    );

    always_comb begin
        state_nxt = state;
        pc_d      = program_counter;
        start_acc = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    start_acc = 1'b1;
                    pc_d      = RESET_PC;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A halting instruction leaves the PC on its own address.
                if (stall)
                    pc_d = program_counter;
                else if (is_halt)
                    state_nxt = HALT;
                else
                    pc_d = pc_seq;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            program_counter <= RESET_PC;
            halted          <= 1'b0;
        end else begin
            state           <= state_nxt;
            program_counter <= pc_d;
            halted          <= (state_nxt == HALT);
        end
    end

`ifdef PC_RETIRE_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            retire_count <= '0;
        else if (start_acc)
            retire_count <= '0;
        else if (pc_valid && (retire_count != 32'hFFFF_FFFF))
            retire_count <= retire_count + 32'd1;
    end
`endif

endmodule
